plab4_net_router_input_terminal_ctrl_credit: RTL and testbench

//  Control for the terminal (injection) input of a ring router with several security domains.

---
 rtl/plab4_net_router_input_terminal_ctrl_credit_pkg.sv | 11 +
 rtl/plab4_net_credit_counter.sv | 23 ++
 rtl/plab4_net_router_input_terminal_ctrl_credit.sv | 105 ++++++++++
 tb/tb_plab4_net_router_input_terminal_ctrl_credit.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/plab4_net_router_input_terminal_ctrl_credit_pkg.sv
// plab4_net_router_input_terminal_ctrl_credit_pkg: ring route encodings and request bit indices
package plab4_net_router_input_terminal_ctrl_credit_pkg;
    typedef enum logic [1:0] {
        ROUTE_PREV = 2'b00,
        ROUTE_TERM = 2'b01,
        ROUTE_NEXT = 2'b10
    } route_t;
    localparam int REQ_NEXT = 2;
    localparam int REQ_TERM = 1;
    localparam int REQ_PREV = 0;
endpackage

// File: rtl/plab4_net_credit_counter.sv
// plab4_net_credit_counter: one downstream credit count, saturating at p_num_credits
//   clk, reset : clock, async active-high reset (count -> p_num_credits)
//   inc, dec   : credit returned / credit consumed this cycle
//   count      : current credits
//   ovf        : return arrived while already full (count holds)
module plab4_net_credit_counter #(
    parameter int p_num_credits = 4,
    localparam int c_nbits = $clog2(p_num_credits + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    output logic [c_nbits-1:0] count,
    output logic               ovf
);
    localparam logic [c_nbits-1:0] c_max = c_nbits'(p_num_credits);
    assign ovf = inc && !dec && count == c_max;
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= c_max;
        else if (inc && !dec && !ovf) count <= count + 1'b1;
        else if (dec && !inc) count <= count - 1'b1;
endmodule

// File: rtl/plab4_net_router_input_terminal_ctrl_credit.sv
// plab4_net_router_input_terminal_ctrl_credit: terminal-input control with per-domain credits
//   cur_sd, dest, in_dom, in_val -> in_rdy : head message routing and handshake
//   reqs/grants                          : {NEXT, TERM, PREV} arbiter interface
//   cred_{west,east}_{val,dom}           : returned credits
//   num_free_{west,east}                 : credits of the current slot's domain
//   err, stall_sat                       : sticky credit error, stall saturation
module plab4_net_router_input_terminal_ctrl_credit
    import plab4_net_router_input_terminal_ctrl_credit_pkg::*;
#(
    parameter int p_router_id   = 0,
    parameter int p_num_routers = 8,
    parameter int p_num_domains = 2,
    parameter int p_num_credits = 4,
    parameter int p_bubble      = 1,
    parameter int p_stall_nbits = 4,
    localparam int c_dest_nbits = $clog2(p_num_routers),
    localparam int c_dom_nbits  = p_num_domains > 1 ? $clog2(p_num_domains) : 1,
    localparam int c_cred_nbits = $clog2(p_num_credits + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [c_dom_nbits-1:0]  cur_sd,
    input  logic [c_dest_nbits-1:0] dest,
    input  logic [c_dom_nbits-1:0]  in_dom,
    input  logic                    in_val,
    output logic                    in_rdy,
    output logic [2:0]              reqs,
    input  logic [2:0]              grants,
    input  logic                    cred_west_val,
    input  logic [c_dom_nbits-1:0]  cred_west_dom,
    input  logic                    cred_east_val,
    input  logic [c_dom_nbits-1:0]  cred_east_dom,
    output logic [c_cred_nbits-1:0] num_free_west,
    output logic [c_cred_nbits-1:0] num_free_east,
    output logic                    err,
    output logic                    stall_sat
);
    localparam logic [c_dest_nbits:0]   c_n    = (c_dest_nbits + 1)'(p_num_routers);
    localparam logic [c_dest_nbits:0]   c_off  = (c_dest_nbits + 1)'(p_num_routers - p_router_id);
    localparam logic [c_dest_nbits:0]   c_half = (c_dest_nbits + 1)'(p_num_routers / 2);
    localparam logic [c_dom_nbits:0]    c_nd   = (c_dom_nbits + 1)'(p_num_domains);
    localparam logic [c_cred_nbits-1:0] c_thr  = c_cred_nbits'(p_bubble != 0 ? 2 : 1);

    logic [c_dest_nbits:0]   sum, fwd;
    route_t                  route;
    logic                    sd_ok, elig, fire, fire_west, fire_east;
    logic [c_cred_nbits-1:0] west_cnt [p_num_domains];
    logic [c_cred_nbits-1:0] east_cnt [p_num_domains];
    logic [p_num_domains-1:0] west_ovf, east_ovf;
    logic [p_stall_nbits-1:0] stall;

    // (dest - id) mod N without a divider: offset by N-id, then fold once
    assign sum   = {1'b0, dest} + c_off;
    assign fwd   = sum >= c_n ? sum - c_n : sum;
    assign route = fwd == '0 ? ROUTE_TERM : fwd <= c_half ? ROUTE_NEXT : ROUTE_PREV;

    assign sd_ok = {1'b0, cur_sd} < c_nd;
    assign elig  = in_val && in_dom == cur_sd && {1'b0, in_dom} < c_nd && !reset;
    assign num_free_west = sd_ok ? west_cnt[cur_sd] : '0;
    assign num_free_east = sd_ok ? east_cnt[cur_sd] : '0;

    always_comb begin
        reqs = '0;
        reqs[REQ_TERM] = elig && route == ROUTE_TERM;
        reqs[REQ_NEXT] = elig && route == ROUTE_NEXT && num_free_west >= c_thr;
        reqs[REQ_PREV] = elig && route == ROUTE_PREV && num_free_east >= c_thr;
    end

    assign in_rdy    = |(reqs & grants);
    assign fire      = in_val && in_rdy;
    assign fire_west = fire && reqs[REQ_NEXT];
    assign fire_east = fire && reqs[REQ_PREV];

    for (genvar d = 0; d < p_num_domains; d++) begin : g_dom
        plab4_net_credit_counter #(.p_num_credits(p_num_credits)) u_west (
            .clk   (clk),
            .reset (reset),
            .inc   (cred_west_val && cred_west_dom == c_dom_nbits'(d)),
            .dec   (fire_west && cur_sd == c_dom_nbits'(d)),
            .count (west_cnt[d]),
            .ovf   (west_ovf[d])
        );
        plab4_net_credit_counter #(.p_num_credits(p_num_credits)) u_east (
            .clk   (clk),
            .reset (reset),
            .inc   (cred_east_val && cred_east_dom == c_dom_nbits'(d)),
            .dec   (fire_east && cur_sd == c_dom_nbits'(d)),
            .count (east_cnt[d]),
            .ovf   (east_ovf[d])
        );
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) err <= 1'b0;
        else if (|west_ovf || |east_ovf
                 || (cred_west_val && {1'b0, cred_west_dom} >= c_nd)
                 || (cred_east_val && {1'b0, cred_east_dom} >= c_nd)) err <= 1'b1;

    always_ff @(posedge clk or posedge reset)
        if (reset) stall <= '0;
        else if (!in_val || fire) stall <= '0;
        else if (!stall_sat) stall <= stall + 1'b1;

    assign stall_sat = &stall;
endmodule

// File: tb/tb_plab4_net_router_input_terminal_ctrl_credit.sv
// tb_plab4_net_router_input_terminal_ctrl_credit: directed vector bench for the terminal input control
module tb_plab4_net_router_input_terminal_ctrl_credit;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [0:0] cur_sd = '0;
    logic [2:0] dest = '0;
    logic [0:0] in_dom = '0;
    logic       in_val = 1'b0;
    logic       in_rdy;
    logic [2:0] reqs;
    logic [2:0] grants = '0;
    logic       cred_west_val = 1'b0;
    logic [0:0] cred_west_dom = '0;
    logic       cred_east_val = 1'b0;
    logic [0:0] cred_east_dom = '0;
    logic [2:0] num_free_west, num_free_east;
    logic       err, stall_sat;

    int n_vec = 0;
    int n_bad = 0;

    plab4_net_router_input_terminal_ctrl_credit dut (
        .clk           (clk),
        .reset         (reset),
        .cur_sd        (cur_sd),
        .dest          (dest),
        .in_dom        (in_dom),
        .in_val        (in_val),
        .in_rdy        (in_rdy),
        .reqs          (reqs),
        .grants        (grants),
        .cred_west_val (cred_west_val),
        .cred_west_dom (cred_west_dom),
        .cred_east_val (cred_east_val),
        .cred_east_dom (cred_east_dom),
        .num_free_west (num_free_west),
        .num_free_east (num_free_east),
        .err           (err),
        .stall_sat     (stall_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sd;
        logic [2:0] dest;
        logic       dom;
        logic       val;
        logic [2:0] gr;
        logic       cwv, cwd, cev, ced;
        logic [2:0] er;
        logic       erdy;
        logic [2:0] ew, ee;
        logic       eerr, esat;
    } vec_t;

    vec_t tbl [25];

    task automatic drive(input logic sd, input logic [2:0] d, input logic dm, input logic v,
                         input logic [2:0] g, input logic cwv, cwd, cev, ced);
        cur_sd = sd; dest = d; in_dom = dm; in_val = v; grants = g;
        cred_west_val = cwv; cred_west_dom = cwd; cred_east_val = cev; cred_east_dom = ced;
    endtask

    task automatic check(input string nm, input logic [2:0] er, input logic erdy,
                         input logic [2:0] ew, ee, input logic eerr, esat);
        n_vec++;
        if ({reqs, in_rdy, num_free_west, num_free_east, err, stall_sat} !== {er, erdy, ew, ee, eerr, esat}) begin
            n_bad++;
            $display("FAIL %s: got reqs=%b rdy=%b west=%0d east=%0d err=%b sat=%b, expected reqs=%b rdy=%b west=%0d east=%0d err=%b sat=%b",
                     nm, reqs, in_rdy, num_free_west, num_free_east, err, stall_sat, er, erdy, ew, ee, eerr, esat);
        end
    endtask

    initial begin
        //          sd dest dom val gr     cwv cwd cev ced  reqs   rdy west east err sat
        tbl[0]  = '{0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 4, 4, 0, 0};
        tbl[1]  = '{1, 0, 1, 0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 4, 4, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 3'b010, 0, 0, 0, 0, 3'b010, 1, 4, 4, 0, 0};
        tbl[3]  = '{0, 4, 0, 1, 3'b000, 0, 0, 0, 0, 3'b100, 0, 4, 4, 0, 0};
        tbl[4]  = '{0, 5, 0, 1, 3'b000, 0, 0, 0, 0, 3'b001, 0, 4, 4, 0, 0};
        tbl[5]  = '{0, 2, 0, 1, 3'b100, 0, 0, 0, 0, 3'b100, 1, 4, 4, 0, 0};
        tbl[6]  = '{0, 2, 0, 1, 3'b100, 0, 0, 0, 0, 3'b100, 1, 3, 4, 0, 0};
        tbl[7]  = '{0, 2, 0, 1, 3'b100, 0, 0, 0, 0, 3'b100, 1, 2, 4, 0, 0};
        tbl[8]  = '{0, 2, 0, 1, 3'b100, 0, 0, 0, 0, 3'b000, 0, 1, 4, 0, 0};
        tbl[9]  = '{0, 2, 0, 1, 3'b100, 1, 0, 0, 0, 3'b000, 0, 1, 4, 0, 0};
        tbl[10] = '{0, 2, 0, 1, 3'b000, 0, 0, 0, 0, 3'b100, 0, 2, 4, 0, 0};
        tbl[11] = '{0, 6, 1, 1, 3'b001, 0, 0, 0, 0, 3'b000, 0, 2, 4, 0, 0};
        tbl[12] = '{1, 6, 1, 1, 3'b001, 0, 0, 0, 0, 3'b001, 1, 4, 4, 0, 0};
        tbl[13] = '{1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 4, 3, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 2, 4, 0, 0};
        tbl[15] = '{0, 2, 0, 1, 3'b100, 1, 0, 0, 0, 3'b100, 1, 2, 4, 0, 0};
        tbl[16] = '{0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 2, 4, 0, 0};
        tbl[17] = '{0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 3'b000, 0, 2, 4, 0, 0};
        tbl[18] = '{0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 3'b000, 0, 3, 4, 0, 0};
        tbl[19] = '{0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 3'b000, 0, 4, 4, 0, 0};
        tbl[20] = '{0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 4, 4, 1, 0};
        tbl[21] = '{1, 0, 0, 0, 3'b000, 0, 0, 1, 1, 3'b000, 0, 4, 3, 1, 0};
        tbl[22] = '{1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 4, 4, 1, 0};
        tbl[23] = '{1, 0, 0, 1, 3'b010, 0, 0, 0, 0, 3'b000, 0, 4, 4, 1, 0};
        tbl[24] = '{1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 4, 4, 1, 0};

        drive(0, 0, 0, 1, 3'b010, 0, 0, 0, 0);
        @(negedge clk);
        #1 check("reset_sd0", 3'b000, 0, 4, 4, 0, 0);
        cur_sd = 1; in_dom = 1;
        #1 check("reset_sd1", 3'b000, 0, 4, 4, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].sd, tbl[i].dest, tbl[i].dom, tbl[i].val, tbl[i].gr,
                  tbl[i].cwv, tbl[i].cwd, tbl[i].cev, tbl[i].ced);
            #1 check($sformatf("vec%0d", i), tbl[i].er, tbl[i].erdy, tbl[i].ew, tbl[i].ee, tbl[i].eerr, tbl[i].esat);
            @(negedge clk);
        end

        // 15 stalled cycles saturate the 4-bit counter
        drive(0, 0, 0, 1, 3'b000, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) @(negedge clk);
        #1 check("stall_14", 3'b010, 0, 4, 4, 1, 0);
        @(negedge clk);
        #1 check("stall_15", 3'b010, 0, 4, 4, 1, 1);
        drive(0, 2, 0, 1, 3'b100, 0, 0, 0, 0);
        #1 check("stall_fire", 3'b100, 1, 4, 4, 1, 1);
        @(negedge clk);
        grants = 3'b000;
        #1 check("stall_cleared", 3'b100, 0, 3, 4, 1, 0);
        for (int i = 0; i < 15; i++) @(negedge clk);
        #1 check("stall_again", 3'b100, 0, 3, 4, 1, 1);
        #2 reset = 1'b1;
        #1 check("async_reset", 3'b000, 0, 4, 4, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("after_reset", 3'b100, 0, 4, 4, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
